gf163_mod_reduce: RTL

//  Sequential modular reduction stage directly downstream of the 163-bit overlap-free Karatsuba multiplier.

---
 rtl/gf163_mod_reduce.sv | 69 ++++++
 1 files changed

// File: rtl/gf163_mod_reduce.sv
// gf163_mod_reduce: two-fold sequential reduction of a 2M-1 bit carry-less product modulo x^M + TAPS(x).
// The fold network sits between registers so it never stacks with the upstream multiplier depth.
module gf163_mod_reduce #(
    parameter int M = 163,
    parameter logic [M-1:0] TAPS = 'hC9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [2*M-2:0] in_prod_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [M-1:0]   out_res_o,
    output logic           busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FOLD1 = 2'd1;
    localparam logic [1:0] FOLD2 = 2'd2;
    localparam logic [1:0] OUTS  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [2*M-2:0] acc_q, acc_d, tap_prod, fold_v;
    logic [M-2:0]   h;

    // h * TAPS lands at most deg(TAPS) bits above M, so the second fold clears it.
    always_comb begin
        h = acc_q[2*M-2:M];
        tap_prod = '0;
        for (int j = 0; j < M; j++)
            if (TAPS[j]) tap_prod = tap_prod ^ ({{M{1'b0}}, h} << j);
        fold_v = {{(M-1){1'b0}}, acc_q[M-1:0]} ^ tap_prod;
    end

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                acc_d = in_prod_i;
                state_d = FOLD1;
            end
            FOLD1: begin
                acc_d = fold_v;
                state_d = FOLD2;
            end
            FOLD2: begin
                acc_d = fold_v;
                state_d = OUTS;
            end
            default: if (out_ready_i) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
        end
    end

    assign in_ready_o = state_q == IDLE;
    assign busy_o = state_q != IDLE;
    assign out_valid_o = state_q == OUTS;
    assign out_res_o = out_valid_o ? acc_q[M-1:0] : '0;
endmodule
